// File: rtl/button_event.sv
// Button event decoder: press/release strobes, long-press strobe after HOLD_TICKS, and
// optional auto-repeat while long-held (enabled by defining BUTTON_EVENT_REPEAT_EN).
module button_event #(
    parameter int TICK_DIV     = 1000000,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic db_signal,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                db_q;
    logic [PRESC_W-1:0]  presc;
    logic [TICK_W-1:0]   tick_cnt;
    logic                rise, fall, tick, hold_hit, rep_hit;
    logic                press_nxt, release_nxt, long_nxt, repeat_nxt;

    assign rise     = db_signal & ~db_q;
    assign fall     = ~db_signal & db_q;
    assign tick     = (state != IDLE) && (presc == PRESC_W'(TICK_DIV - 1));
    assign hold_hit = (state == PRESSED) && tick && (tick_cnt == TICK_W'(HOLD_TICKS - 1));
`ifdef BUTTON_EVENT_REPEAT_EN
    assign rep_hit  = (state == LONG) && tick && (tick_cnt == TICK_W'(REPEAT_TICKS - 1));
`else
    assign rep_hit  = 1'b0;
`endif
    assign held     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            db_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            db_q  <= db_signal;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = PRESSED;
            PRESSED: if (fall) state_nxt = IDLE;
                     else if (hold_hit) state_nxt = LONG;
            LONG:    if (fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Release wins over a coincident threshold tick, so the pulses stay mutually exclusive.
    always_comb begin
        press_nxt   = (state == IDLE) && rise;
        release_nxt = (state != IDLE) && fall;
        long_nxt    = hold_hit && !fall;
        repeat_nxt  = rep_hit && !fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

    // Prescaler and tick counter restart from zero on every new press.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE || fall) begin
            presc    <= '0;
            tick_cnt <= '0;
        end else begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) begin
                if (hold_hit || rep_hit)
                    tick_cnt <= '0;
`ifdef BUTTON_EVENT_REPEAT_EN
                else
                    tick_cnt <= tick_cnt + TICK_W'(1);
`else
                else if (state == PRESSED)
                    tick_cnt <= tick_cnt + TICK_W'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Randomized scoreboard bench for button_event; expectations come from a cycle-count
// model of press timing (press cycle + HOLD*DIV, then every REPEAT*DIV when enabled).
module tb_button_event;

    localparam int TD = 4;
    localparam int HT = 3;
    localparam int RT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic db_signal = 1'b0;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    button_event #(.TICK_DIV(TD), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)) dut (
        .clk(clk),
        .reset(reset),
        .db_signal(db_signal),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .held(held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    // Model state: sample index, previous level, whether a press is active and when it was reported.
    int   t = 0;
    logic m_prev = 1'b0;
    logic m_in = 1'b0;
    int   m_press_cyc = 0;

    task automatic step(input logic d, input logic r);
        logic [4:0] e;
        int o, dd;
        e = '0;
        db_signal = d;
        reset = r;
        o = t + 1;
        if (r) begin
            m_prev = 1'b0;
            m_in = 1'b0;
        end else begin
            if (d && !m_prev) begin
                m_in = 1'b1;
                m_press_cyc = o;
                e[4] = 1'b1;
            end else if (!d && m_prev) begin
                m_in = 1'b0;
                e[3] = 1'b1;
            end else if (m_in) begin
                dd = o - m_press_cyc;
                if (dd == HT * TD)
                    e[2] = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                else if (dd > HT * TD && ((dd - HT * TD) % (RT * TD)) == 0)
                    e[1] = 1'b1;
`endif
            end
            e[0] = m_in;
            m_prev = d;
        end
        @(posedge clk);
        exp_q.push_back(e);
        t++;
        #1;
    endtask

    task automatic hold(input int n, input logic d);
        repeat (n) step(d, 1'b0);
    endtask

    // Monitor: one expected vector per sampled cycle, compared away from the clock edge.
    always @(negedge clk) begin
        logic [4:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual press/rel/long/rep/held=%b required %b", $time, a, e);
            end
            checks++;
            if ($countones(a[4:1]) > 1) begin
                errors++;
                $display("FAIL exclusive_pulses t=%0t actual %b required at most one pulse", $time, a[4:1]);
            end
        end
    end

    initial begin
        int hi, lo;
        repeat (3) step(1'b0, 1'b1);
        hold(6, 1'b0);
        hold(45, 1'b1);  hold(10, 1'b0);           // long press with repeats
        hold(8, 1'b1);   hold(6, 1'b0);            // short press
        hold(12, 1'b1);  hold(5, 1'b0);            // release on the threshold tick
        hold(13, 1'b1);  hold(5, 1'b0);            // release right after long
        hold(25, 1'b1);
        step(1'b1, 1'b1); step(1'b1, 1'b1);        // reset during LONG, button still down
        hold(20, 1'b1);  hold(5, 1'b0);
        hold(5, 1'b1);   hold(1, 1'b0);  hold(14, 1'b1); hold(3, 1'b0);
        hold(100, 1'b1); hold(4, 1'b0);
        for (int s = 0; s < 40; s++) begin
            hi = $urandom_range(1, 50);
            lo = $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) begin
                hold(hi / 2 + 1, 1'b1);
                repeat ($urandom_range(1, 2)) step(($urandom_range(0, 1) == 1), 1'b1);
            end
            hold(hi, 1'b1);
            hold(lo, 1'b0);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clock cycles per hold tick (10 ms at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter HOLD_TICKS, default 50, ticks of continuous press before long press; legal range >= 1.
REQ-003 SHALL have parameter REPEAT_TICKS, default 10, ticks between auto-repeat pulses; legal range >= 1.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port db_signal  input  1  debounced button level, 1 = pressed, synchronous to clk.
REQ-007 SHALL have port press_pulse  output  1  one-cycle strobe on press.
REQ-008 SHALL have port release_pulse  output  1  one-cycle strobe on release.
REQ-009 SHALL have port long_pulse  output  1  one-cycle strobe when the press reaches HOLD_TICKS.
REQ-010 SHALL have port repeat_pulse  output  1  one-cycle auto-repeat strobe while long-held.
REQ-011 SHALL have port held  output  1  level, high while the FSM is not in IDLE.

Function
REQ-012 SHALL register db_signal into db_q each cycle; edges SHALL be detected as db_signal != db_q.
REQ-013 SHALL implement FSM states IDLE, PRESSED, LONG.
REQ-014 IDLE -> PRESSED on rising edge; press_pulse SHALL be high in the cycle after db_signal is first sampled high (1-cycle latency).
REQ-015 SHALL clear the prescaler and tick counter on entry to PRESSED; the prescaler SHALL be held at 0 in IDLE.
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 in PRESSED/LONG, wrapping to 0; a tick SHALL occur on the wrap cycle.
REQ-017 In PRESSED, the tick counter SHALL increment per tick; on reaching HOLD_TICKS the FSM SHALL go to LONG, assert long_pulse for one cycle, and clear the tick counter.
REQ-018 long_pulse SHALL therefore assert exactly HOLD_TICKS*TICK_DIV cycles after press_pulse.
REQ-019 In LONG, repeat_pulse SHALL assert for one cycle every REPEAT_TICKS*TICK_DIV cycles after long_pulse, and the tick counter SHALL wrap to 0 on each repeat.
REQ-020 Falling edge in PRESSED or LONG SHALL go to IDLE and assert release_pulse for one cycle, with 1-cycle latency.
REQ-021 Release coincident with a threshold tick SHALL take priority: release_pulse only; no long_pulse or repeat_pulse that cycle.
REQ-022 At most one of press_pulse, release_pulse, long_pulse, repeat_pulse SHALL be high in any cycle.
REQ-023 A release followed by a press on the next sampled cycle SHALL produce release_pulse then press_pulse on consecutive cycles, restarting timing.
REQ-024 Counters SHALL be sized to hold their maximum value without overflow; no count SHALL saturate or wrap except as specified.

Reset
REQ-025 On reset, the FSM SHALL go to IDLE; db_q, prescaler, and tick counter SHALL be 0; all five outputs SHALL be 0 in the following cycle.
REQ-026 Reset SHALL take priority over all other inputs in the same cycle.
REQ-027 If db_signal is high when reset deasserts, the block SHALL treat it as a new press (press_pulse one cycle after the first non-reset sample).

Configuration
REQ-028 Macro BUTTON_EVENT_REPEAT_EN defined: auto-repeat SHALL behave per REQ-019.
REQ-029 Macro BUTTON_EVENT_REPEAT_EN undefined: repeat_pulse SHALL be constant 0; in LONG, the tick counter SHALL stay at 0; LONG SHALL persist until release; all other behaviour SHALL be unchanged.

Verification (TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2 unless noted)
REQ-030 db_signal high at cycle 10, held -> press_pulse at 11, long_pulse at 23, repeat_pulse at 31, 39, 47; held high from 11.
REQ-031 db_signal high at cycle 10, low at cycle 18 -> press_pulse at 11, release_pulse at 19, no long_pulse; held low from 19.
REQ-032 db_signal falls in the same cycle the tick counter would reach HOLD_TICKS (low at cycle 22) -> release_pulse at 23, no long_pulse.
REQ-033 Reset asserted at cycle 30 during LONG with db_signal held high, deasserted at 32 -> all outputs 0 at 31-32, press_pulse at 33, long_pulse at 45.
REQ-034 BUTTON_EVENT_REPEAT_EN undefined, db_signal held high for 100 cycles -> exactly one press_pulse and one long_pulse, repeat_pulse never high, release_pulse one cycle after the fall.
